// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR access controller.
// Contents:
//   DATA_W/NREG/AW   register width, register count, index width
//   reg_idx_t        register index
//   word_t           register/operand word
//   dec_req_t        decoded-instruction register usage
//   ex_bundle_t      operand bundle handed to execute
//   state_t          output-register occupancy state
//   sel_operand()    source operand select with write-back bypass
package gpr_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned AW     = 3;

    typedef logic [AW-1:0]     reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        reg_idx_t rs1;
        logic     rs1_en;
        reg_idx_t rs2;
        logic     rs2_en;
        reg_idx_t rd;
        logic     rd_en;
    } dec_req_t;

    typedef struct packed {
        word_t    op1;
        word_t    op2;
        reg_idx_t rd;
        logic     rd_en;
    } ex_bundle_t;

    typedef enum logic {EMPTY, FULL} state_t;

    // A disabled source reads as zero. A same-cycle write-back to the source
    // register wins over the (stale) register file contents.
    function automatic word_t sel_operand(input logic     en,
                                          input reg_idx_t rs,
                                          input word_t    rf_data,
                                          input logic     wb_valid,
                                          input reg_idx_t wb_rd,
                                          input word_t    wb_data);
        word_t op;
        op = '0;
        if (en) begin
            op = (wb_valid && (wb_rd == rs)) ? wb_data : rf_data;
        end
        return op;
    endfunction

endpackage

// File: rtl/gpr_access_ctrl_if.sv
// Bus bundle between the GPR access controller and its neighbours
// (decode, register file, write-back, execute).
// Modports:
//   slave   the controller side
//   master  the environment side (decode, GPR file, write-back, execute)
// Signal groups:
//   dec_*       decoded instruction in, dec_ready back-pressure out
//   rf_rd*/wr*  GPR read ports (addr out, data in) and write port (out)
//   wb_*        write-back result bus
//   ex_*        operand bundle to execute, valid/ready handshake
//   pending, stall_cnt, wb_err   debug/status
interface gpr_access_ctrl_if;
    import gpr_pkg::*;

    logic             dec_valid;
    logic             dec_ready;
    reg_idx_t         dec_rs1;
    reg_idx_t         dec_rs2;
    logic             dec_rs1_en;
    logic             dec_rs2_en;
    reg_idx_t         dec_rd;
    logic             dec_rd_en;

    logic             rf_rd1;
    logic             rf_rd2;
    reg_idx_t         rf_rd1_addr;
    reg_idx_t         rf_rd2_addr;
    word_t            rf_rd1_data;
    word_t            rf_rd2_data;

    logic             rf_wr;
    reg_idx_t         rf_wr_addr;
    word_t            rf_wr_data;

    logic             wb_valid;
    reg_idx_t         wb_rd;
    word_t            wb_data;

    logic             ex_valid;
    logic             ex_ready;
    word_t            ex_op1;
    word_t            ex_op2;
    reg_idx_t         ex_rd;
    logic             ex_rd_en;

    logic [NREG-1:0]  pending;
    logic [15:0]      stall_cnt;
    logic             wb_err;

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en, dec_rd, dec_rd_en,
        output dec_ready,
        output rf_rd1, rf_rd2, rf_rd1_addr, rf_rd2_addr,
        input  rf_rd1_data, rf_rd2_data,
        output rf_wr, rf_wr_addr, rf_wr_data,
        input  wb_valid, wb_rd, wb_data,
        output ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_en,
        input  ex_ready,
        output pending, stall_cnt, wb_err
    );

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rs1_en, dec_rs2_en, dec_rd, dec_rd_en,
        input  dec_ready,
        input  rf_rd1, rf_rd2, rf_rd1_addr, rf_rd2_addr,
        output rf_rd1_data, rf_rd2_data,
        input  rf_wr, rf_wr_addr, rf_wr_data,
        output wb_valid, wb_rd, wb_data,
        input  ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_en,
        output ex_ready,
        input  pending, stall_cnt, wb_err
    );

endinterface

// File: rtl/gpr_scoreboard.sv
// Pending-destination scoreboard for the GPR access controller.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   set_en, set_idx      mark a register as having an in-flight write
//   clr_en, clr_idx      write-back completing for a register
//   look_idx[2:0]        registers to look up (rs1, rs2, rd)
//   look_busy[2:0]       looked-up register is pending and not being
//                        written back this cycle
//   pending              current scoreboard vector
//   wb_err               sticky: a write-back hit a non-pending register
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  reg_idx_t             set_idx,
    input  logic                 clr_en,
    input  reg_idx_t             clr_idx,
    input  reg_idx_t [2:0]       look_idx,
    output logic [2:0]           look_busy,
    output logic [NREG-1:0]      pending,
    output logic                 wb_err
);

    logic [NREG-1:0] pending_q, pending_d;
    logic            wb_err_q;

    // Set is applied after clear so an accept that targets the register
    // being written back leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (clr_en) begin
            pending_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            pending_d[set_idx] = 1'b1;
        end
    end

    // The write-back in flight this cycle resolves the hazard, so it masks
    // the lookup (its data arrives through the bypass).
    always_comb begin
        look_busy = '0;
        for (int i = 0; i < 3; i++) begin
            look_busy[i] = pending_q[look_idx[i]] & ~(clr_en & (clr_idx == look_idx[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (clr_en && !pending_q[clr_idx]) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    assign pending = pending_q;
    assign wb_err  = wb_err_q;

endmodule

// File: rtl/gpr_access_ctrl.sv
// Requester-side controller for the 8x16 GPR file, between decode and
// execute. Drives both GPR read ports from the decode inputs, bypasses
// same-cycle write-back data, tracks in-flight destinations in a
// scoreboard, stalls decode on RAW/WAW hazards, registers the operand
// bundle towards execute behind a valid/ready handshake and forwards the
// write-back bus to the GPR write port.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        gpr_access_ctrl_if.slave (decode, GPR ports, write-back,
//              execute handshake, pending/stall_cnt/wb_err status)
module gpr_access_ctrl
    import gpr_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    gpr_access_ctrl_if.slave   bus
);

    dec_req_t        req;
    state_t          state_q;
    ex_bundle_t      bundle_q;
    logic [15:0]     stall_cnt_q;

    word_t           op1, op2;
    reg_idx_t [2:0]  look_idx;
    logic [2:0]      look_busy;
    logic            hazard;
    logic            ex_valid;
    logic            dec_ready;
    logic            accept;

    always_comb begin
        req        = '0;
        req.rs1    = bus.dec_rs1;
        req.rs1_en = bus.dec_rs1_en;
        req.rs2    = bus.dec_rs2;
        req.rs2_en = bus.dec_rs2_en;
        req.rd     = bus.dec_rd;
        req.rd_en  = bus.dec_rd_en;
    end

    // GPR read ports follow decode directly; data returns combinationally.
    assign bus.rf_rd1      = bus.dec_valid & req.rs1_en;
    assign bus.rf_rd2      = bus.dec_valid & req.rs2_en;
    assign bus.rf_rd1_addr = req.rs1;
    assign bus.rf_rd2_addr = req.rs2;

    // Write-back goes straight to the GPR write port, even for a register
    // that was not pending (that case only raises wb_err).
    assign bus.rf_wr      = bus.wb_valid;
    assign bus.rf_wr_addr = bus.wb_rd;
    assign bus.rf_wr_data = bus.wb_data;

    assign op1 = sel_operand(req.rs1_en, req.rs1, bus.rf_rd1_data,
                             bus.wb_valid, bus.wb_rd, bus.wb_data);
    assign op2 = sel_operand(req.rs2_en, req.rs2, bus.rf_rd2_data,
                             bus.wb_valid, bus.wb_rd, bus.wb_data);

    assign look_idx = {req.rd, req.rs2, req.rs1};

    gpr_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (accept & req.rd_en),
        .set_idx   (req.rd),
        .clr_en    (bus.wb_valid),
        .clr_idx   (bus.wb_rd),
        .look_idx  (look_idx),
        .look_busy (look_busy),
        .pending   (bus.pending),
        .wb_err    (bus.wb_err)
    );

    assign hazard = (req.rs1_en & look_busy[0]) |
                    (req.rs2_en & look_busy[1]) |
                    (req.rd_en  & look_busy[2]);

    assign ex_valid = (state_q == FULL);

    // Independent of dec_valid so decode can use it to steer issue.
    assign dec_ready = ~hazard & (~ex_valid | bus.ex_ready);
    assign accept    = bus.dec_valid & dec_ready;

    // Output register and occupancy state. The bundle only loads on accept,
    // and accept while FULL requires ex_ready, so the bundle is held stable
    // while execute back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            bundle_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_q <= FULL;
                    end
                end
                FULL: begin
                    if (bus.ex_ready && !accept) begin
                        state_q <= EMPTY;
                    end
                end
            endcase

            if (accept) begin
                bundle_q.op1   <= op1;
                bundle_q.op2   <= op2;
                bundle_q.rd    <= req.rd;
                bundle_q.rd_en <= req.rd_en;
            end

            // Only hazard stalls count; back-pressure stalls do not.
            if (bus.dec_valid && hazard && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.dec_ready = dec_ready;
    assign bus.ex_valid  = ex_valid;
    assign bus.ex_op1    = bundle_q.op1;
    assign bus.ex_op2    = bundle_q.op2;
    assign bus.ex_rd     = bundle_q.rd;
    assign bus.ex_rd_en  = bundle_q.rd_en;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
